// File: rtl/bsg_manycore_edge_link_if.sv
// Handshake and data bundle between external orig-format links, the mesh edge and
// the return network. Signal suffixes are written from the adapter's point of view.
interface bsg_manycore_edge_link_if #(
  parameter int num_links_p     = 4,
  parameter int x_cord_width_p  = 2,
  parameter int y_cord_width_p  = 3,
  parameter int payload_width_p = 70
);
  localparam int cw     = x_cord_width_p + y_cord_width_p;
  localparam int orig_w = payload_width_p + cw;
  localparam int pkt_w  = orig_w + cw;
  localparam int ret_w  = 5 + cw;

  logic [num_links_p*orig_w-1:0] in_data_i;
  logic [num_links_p-1:0]        in_v_i;
  logic [num_links_p-1:0]        in_ready_o;

  logic [num_links_p*pkt_w-1:0]  array_data_o;
  logic [num_links_p-1:0]        array_v_o;
  logic [num_links_p-1:0]        array_ready_i;

  logic [num_links_p*pkt_w-1:0]  array_data_i;
  logic [num_links_p-1:0]        array_v_i;
  logic [num_links_p-1:0]        array_ready_o;

  logic [num_links_p*orig_w-1:0] out_data_o;
  logic [num_links_p-1:0]        out_v_o;
  logic [num_links_p-1:0]        out_ready_i;

  logic [num_links_p*ret_w-1:0]  ret_data_i;
  logic [num_links_p-1:0]        ret_v_i;
  logic [num_links_p-1:0]        ret_ready_o;

  // master is the surrounding environment, slave is the edge adapter
  modport master (
    output in_data_i, in_v_i, array_ready_i, array_data_i, array_v_i,
           out_ready_i, ret_data_i, ret_v_i,
    input  in_ready_o, array_data_o, array_v_o, array_ready_o,
           out_data_o, out_v_o, ret_ready_o
  );

  modport slave (
    input  in_data_i, in_v_i, array_ready_i, array_data_i, array_v_i,
           out_ready_i, ret_data_i, ret_v_i,
    output in_ready_o, array_data_o, array_v_o, array_ready_o,
           out_data_o, out_v_o, ret_ready_o
  );
endinterface

// File: rtl/bsg_manycore_edge_link.sv
// Edge adapter for one stubbed mesh edge: credit-limited ingress with return-field
// insertion, registered egress stripping, and return-network termination per link.
module bsg_manycore_edge_link #(
  parameter int num_links_p       = 4,
  parameter int x_cord_width_p    = 2,
  parameter int y_cord_width_p    = 3,
  parameter int payload_width_p   = 70,
  parameter int fifo_els_p        = 2,
  parameter int max_out_credits_p = 16,
  parameter int ret_cord_mode_p   = 0,
  localparam int cw     = x_cord_width_p + y_cord_width_p,
  localparam int orig_w = payload_width_p + cw,
  localparam int pkt_w  = orig_w + cw,
  localparam int crw    = $clog2(max_out_credits_p + 1)
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [num_links_p*cw-1:0]   link_cord_i,
  bsg_manycore_edge_link_if.slave     bus,
  output logic [num_links_p*crw-1:0]  credits_o,
  output logic [num_links_p-1:0]      err_o,
  output logic                        idle_o
);
  localparam int ptr_w = $clog2(fifo_els_p);
  localparam int cnt_w = $clog2(fifo_els_p + 1);
  localparam logic [crw-1:0]   max_cred  = crw'(max_out_credits_p);
  localparam logic [cnt_w-1:0] fifo_cap  = cnt_w'(fifo_els_p);
  localparam logic [ptr_w-1:0] ptr_last  = ptr_w'(fifo_els_p - 1);

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_last) ? '0 : p + ptr_w'(1);
  endfunction

  // Holds every ready low until the first clock edge after reset release.
  logic alive_q;
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) alive_q <= 1'b0;
    else            alive_q <= 1'b1;
  end

  assign bus.ret_ready_o = {num_links_p{alive_q}};

  logic ret_data_unused;
  assign ret_data_unused = ^bus.ret_data_i;

  logic [num_links_p-1:0] link_idle;
  assign idle_o = &link_idle;

  for (genvar l = 0; l < num_links_p; l++) begin : g_link
    logic [orig_w-1:0] mem_q [fifo_els_p];
    logic [ptr_w-1:0]  rd_ptr_q, wr_ptr_q;
    logic [cnt_w-1:0]  count_q;
    logic [crw-1:0]    credits_q, credits_d;
    logic              err_q, err_d;
    logic              stage_v_q;
    logic [orig_w-1:0] stage_data_q;
    logic              fifo_full, fifo_empty, in_ready, enq, deq, inj_v, ret;
    logic              egress_ready, acc;
    logic [orig_w-1:0] head;
    logic [cw-1:0]     ret_field;
    logic [pkt_w-1:0]  pkt_in;
    logic [cw-1:0]     egress_ret_unused;

    assign fifo_full  = (count_q == fifo_cap);
    assign fifo_empty = (count_q == '0);
    assign in_ready   = alive_q & ~fifo_full;
    assign enq        = bus.in_v_i[l] & in_ready;

    assign head      = mem_q[rd_ptr_q];
    assign ret_field = (ret_cord_mode_p != 0) ? link_cord_i[l*cw +: cw] : {cw{1'b1}};
    assign inj_v     = ~fifo_empty & (credits_q < max_cred);
    assign deq       = inj_v & bus.array_ready_i[l];
    assign ret       = alive_q & bus.ret_v_i[l];

    assign bus.in_ready_o[l]                  = in_ready;
    assign bus.array_v_o[l]                   = inj_v;
    assign bus.array_data_o[l*pkt_w +: pkt_w] = {head[orig_w-1:cw], ret_field, head[cw-1:0]};

    // Storage carries no reset; the count alone defines which entries are live.
    always_ff @(posedge clk_i) begin
      if (enq) mem_q[wr_ptr_q] <= bus.in_data_i[l*orig_w +: orig_w];
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (enq) wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (deq) rd_ptr_q <= ptr_inc(rd_ptr_q);
        case ({enq, deq})
          2'b10:   count_q <= count_q + cnt_w'(1);
          2'b01:   count_q <= count_q - cnt_w'(1);
          default: count_q <= count_q;
        endcase
      end
    end

    // A return with nothing outstanding is an error unless an injection cancels it.
    always_comb begin
      credits_d = credits_q;
      err_d     = err_q;
      if (deq && !ret) begin
        credits_d = credits_q + crw'(1);
      end else if (!deq && ret) begin
        if (credits_q == '0) err_d = 1'b1;
        else                 credits_d = credits_q - crw'(1);
      end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        credits_q <= '0;
        err_q     <= 1'b0;
      end else begin
        credits_q <= credits_d;
        err_q     <= err_d;
      end
    end

    assign credits_o[l*crw +: crw] = credits_q;
    assign err_o[l]                = err_q;

    assign pkt_in            = bus.array_data_i[l*pkt_w +: pkt_w];
    assign egress_ret_unused = pkt_in[2*cw-1:cw];
    assign egress_ready      = alive_q & (~stage_v_q | bus.out_ready_i[l]);
    assign acc               = bus.array_v_i[l] & egress_ready;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        stage_v_q    <= 1'b0;
        stage_data_q <= '0;
      end else if (acc) begin
        stage_v_q    <= 1'b1;
        stage_data_q <= {pkt_in[pkt_w-1:2*cw], pkt_in[cw-1:0]};
      end else if (bus.out_ready_i[l]) begin
        stage_v_q    <= 1'b0;
      end
    end

    assign bus.array_ready_o[l]                 = egress_ready;
    assign bus.out_v_o[l]                       = stage_v_q;
    assign bus.out_data_o[l*orig_w +: orig_w]   = stage_data_q;

    assign link_idle[l] = (credits_q == '0) & fifo_empty & ~stage_v_q;
  end

endmodule

// File: tb/tb_bsg_manycore_edge_link.sv
// Directed bench: dut_a runs mode 0 with two credits per link, dut_b runs mode 1 with
// sixteen; a shared async reset exercises mid-operation reset on dut_b.
module tb_bsg_manycore_edge_link;
  localparam int NL = 4;
  localparam int OW = 75;
  localparam int PW = 80;

  logic clk;
  logic reset_n;
  logic [NL*5-1:0] cord_a, cord_b;
  logic [NL*2-1:0] creda;
  logic [NL*5-1:0] credb;
  logic [NL-1:0]   erra, errb;
  logic            idlea, idleb;
  int checks;
  int errors;

  bsg_manycore_edge_link_if #(.num_links_p(NL), .x_cord_width_p(2), .y_cord_width_p(3),
                              .payload_width_p(70)) ifa ();
  bsg_manycore_edge_link_if #(.num_links_p(NL), .x_cord_width_p(2), .y_cord_width_p(3),
                              .payload_width_p(70)) ifb ();

  bsg_manycore_edge_link #(.num_links_p(NL), .x_cord_width_p(2), .y_cord_width_p(3),
    .payload_width_p(70), .fifo_els_p(2), .max_out_credits_p(2), .ret_cord_mode_p(0)) dut_a (
    .clk_i(clk), .reset_n_i(reset_n), .link_cord_i(cord_a), .bus(ifa),
    .credits_o(creda), .err_o(erra), .idle_o(idlea));

  bsg_manycore_edge_link #(.num_links_p(NL), .x_cord_width_p(2), .y_cord_width_p(3),
    .payload_width_p(70), .fifo_els_p(2), .max_out_credits_p(16), .ret_cord_mode_p(1)) dut_b (
    .clk_i(clk), .reset_n_i(reset_n), .link_cord_i(cord_b), .bus(ifb),
    .credits_o(credb), .err_o(errb), .idle_o(idleb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // n = 0 only lets combinational outputs settle after an input change
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] orig(input logic [69:0] p, input logic [4:0] d);
    return {p, d};
  endfunction

  initial begin
    checks = 0; errors = 0;
    reset_n = 1'b0;
    cord_a = '0; cord_b = '0; cord_b[10 +: 5] = 5'h15;
    ifa.in_data_i = '0; ifa.in_v_i = '0; ifa.array_ready_i = '0; ifa.array_data_i = '0;
    ifa.array_v_i = '0; ifa.out_ready_i = '0; ifa.ret_data_i = '0; ifa.ret_v_i = '0;
    ifb.in_data_i = '0; ifb.in_v_i = '0; ifb.array_ready_i = '0; ifb.array_data_i = '0;
    ifb.array_v_i = '0; ifb.out_ready_i = '0; ifb.ret_data_i = '0; ifb.ret_v_i = '0;
    #1;
    checkOutput("rst_in_ready", ifa.in_ready_o, 0);
    checkOutput("rst_ret_ready", ifa.ret_ready_o, 0);
    checkOutput("rst_array_ready", ifa.array_ready_o, 0);
    checkOutput("rst_array_v", ifa.array_v_o, 0);
    checkOutput("rst_out_v", ifa.out_v_o, 0);
    checkOutput("rst_credits", creda, 0);
    checkOutput("rst_err", erra, 0);
    checkOutput("rst_idle", idlea, 1);
    #1 reset_n = 1'b1;
    applyStimulus(1);
    checkOutput("run_in_ready", ifa.in_ready_o, 4'hF);
    checkOutput("run_ret_ready", ifa.ret_ready_o, 4'hF);
    checkOutput("run_array_ready", ifa.array_ready_o, 4'hF);

    $display("[TB] basic injection");
    ifa.array_ready_i = 4'hF;
    ifa.in_data_i[0 +: OW] = orig(70'h1234, 5'h0A);
    ifa.in_v_i[0] = 1'b1;
    applyStimulus(1);
    ifa.in_v_i[0] = 1'b0;
    applyStimulus(0);
    checkOutput("inj_v", ifa.array_v_o[0], 1);
    checkOutput("inj_data", ifa.array_data_o[0 +: PW], {70'h1234, 5'h1F, 5'h0A});
    checkOutput("inj_cred_before", creda[1:0], 0);
    applyStimulus(1);
    checkOutput("inj_cred_after", creda[1:0], 1);
    checkOutput("inj_v_drained", ifa.array_v_o[0], 0);
    checkOutput("inj_busy", idlea, 0);
    ifa.ret_v_i[0] = 1'b1;
    applyStimulus(1);
    ifa.ret_v_i[0] = 1'b0;
    applyStimulus(0);
    checkOutput("ret_cred", creda[1:0], 0);
    checkOutput("ret_idle", idlea, 1);
    checkOutput("ret_no_err", erra, 0);

    $display("[TB] credit stall");
    ifa.in_v_i[0] = 1'b1;
    ifa.in_data_i[0 +: OW] = orig(70'h1, 5'h01);
    applyStimulus(1);
    ifa.in_data_i[0 +: OW] = orig(70'h2, 5'h02);
    applyStimulus(0);
    checkOutput("stall_head1", ifa.array_data_o[0 +: PW], {70'h1, 5'h1F, 5'h01});
    applyStimulus(1);
    ifa.in_data_i[0 +: OW] = orig(70'h3, 5'h03);
    applyStimulus(0);
    checkOutput("stall_head2", ifa.array_data_o[0 +: PW], {70'h2, 5'h1F, 5'h02});
    checkOutput("stall_cred1", creda[1:0], 1);
    applyStimulus(1);
    ifa.in_v_i[0] = 1'b0;
    applyStimulus(0);
    checkOutput("stall_v_low", ifa.array_v_o[0], 0);
    checkOutput("stall_cred2", creda[1:0], 2);
    checkOutput("stall_head3", ifa.array_data_o[0 +: PW], {70'h3, 5'h1F, 5'h03});
    applyStimulus(1);
    checkOutput("stall_hold_v", ifa.array_v_o[0], 0);
    checkOutput("stall_hold_cred", creda[1:0], 2);
    ifa.ret_v_i[0] = 1'b1;
    applyStimulus(1);
    ifa.ret_v_i[0] = 1'b0;
    applyStimulus(0);
    checkOutput("stall_release_cred", creda[1:0], 1);
    checkOutput("stall_release_v", ifa.array_v_o[0], 1);
    applyStimulus(1);
    checkOutput("stall_third_cred", creda[1:0], 2);
    checkOutput("stall_third_empty", ifa.array_v_o[0], 0);
    ifa.ret_v_i[0] = 1'b1;
    applyStimulus(2);
    ifa.ret_v_i[0] = 1'b0;
    applyStimulus(0);
    checkOutput("stall_drain_cred", creda[1:0], 0);

    $display("[TB] simultaneous events");
    ifa.in_v_i[0] = 1'b1;
    ifa.in_data_i[0 +: OW] = orig(70'h4, 5'h04);
    applyStimulus(1);
    ifa.in_data_i[0 +: OW] = orig(70'h5, 5'h05);
    applyStimulus(1);
    ifa.in_v_i[0] = 1'b0;
    ifa.ret_v_i[0] = 1'b1;
    applyStimulus(0);
    checkOutput("sim_cred_pre", creda[1:0], 1);
    checkOutput("sim_v_pre", ifa.array_v_o[0], 1);
    applyStimulus(1);
    checkOutput("sim_cred_hold", creda[1:0], 1);
    checkOutput("sim_v_post", ifa.array_v_o[0], 0);
    applyStimulus(1);
    checkOutput("sim_cred_zero", creda[1:0], 0);
    checkOutput("sim_no_err_yet", erra, 0);
    applyStimulus(1);
    ifa.ret_v_i[0] = 1'b0;
    applyStimulus(0);
    checkOutput("err_set", erra, 4'b0001);
    checkOutput("err_cred_zero", creda[1:0], 0);
    applyStimulus(3);
    checkOutput("err_sticky", erra, 4'b0001);
    ifa.in_data_i[OW +: OW] = orig(70'h6, 5'h06);
    ifa.in_v_i[1] = 1'b1;
    applyStimulus(1);
    ifa.in_v_i[1] = 1'b0;
    ifa.ret_v_i[1] = 1'b1;
    applyStimulus(1);
    ifa.ret_v_i[1] = 1'b0;
    applyStimulus(0);
    checkOutput("net0_cred", creda[3:2], 0);
    checkOutput("net0_no_err", erra, 4'b0001);
    checkOutput("net0_v", ifa.array_v_o[1], 0);

    $display("[TB] fifo full");
    ifa.array_ready_i = 4'b1011;
    ifa.in_v_i[2] = 1'b1;
    ifa.in_data_i[2*OW +: OW] = orig(70'h11, 5'h11);
    applyStimulus(1);
    ifa.in_data_i[2*OW +: OW] = orig(70'h12, 5'h12);
    applyStimulus(1);
    ifa.in_data_i[2*OW +: OW] = orig(70'h13, 5'h13);
    applyStimulus(0);
    checkOutput("full_ready", ifa.in_ready_o[2], 0);
    checkOutput("full_v", ifa.array_v_o[2], 1);
    checkOutput("full_head1", ifa.array_data_o[2*PW +: PW], {70'h11, 5'h1F, 5'h11});
    checkOutput("full_other_link", ifa.in_ready_o[0], 1);
    applyStimulus(1);
    checkOutput("full_ready_hold", ifa.in_ready_o[2], 0);
    checkOutput("full_head1_hold", ifa.array_data_o[2*PW +: PW], {70'h11, 5'h1F, 5'h11});
    checkOutput("full_cred0", creda[5:4], 0);
    ifa.array_ready_i = 4'hF;
    applyStimulus(1);
    checkOutput("full_ready_open", ifa.in_ready_o[2], 1);
    checkOutput("full_head2", ifa.array_data_o[2*PW +: PW], {70'h12, 5'h1F, 5'h12});
    checkOutput("full_cred1", creda[5:4], 1);
    applyStimulus(1);
    ifa.in_v_i[2] = 1'b0;
    applyStimulus(0);
    checkOutput("full_head3", ifa.array_data_o[2*PW +: PW], {70'h13, 5'h1F, 5'h13});
    checkOutput("full_cred2", creda[5:4], 2);
    checkOutput("full_stall", ifa.array_v_o[2], 0);
    ifa.ret_v_i[2] = 1'b1;
    applyStimulus(2);
    ifa.ret_v_i[2] = 1'b0;
    applyStimulus(0);
    checkOutput("full_cred_end", creda[5:4], 1);
    checkOutput("full_empty", ifa.array_v_o[2], 0);
    ifa.ret_v_i[2] = 1'b1;
    applyStimulus(1);
    ifa.ret_v_i[2] = 1'b0;
    applyStimulus(0);
    checkOutput("full_idle", idlea, 1);

    $display("[TB] egress");
    ifa.array_data_i[3*PW +: PW] = {70'hABCDE, 5'h1F, 5'h03};
    ifa.array_v_i[3] = 1'b1;
    ifa.out_ready_i[3] = 1'b0;
    applyStimulus(1);
    ifa.array_v_i[3] = 1'b0;
    applyStimulus(0);
    checkOutput("eg_v", ifa.out_v_o[3], 1);
    checkOutput("eg_data", ifa.out_data_o[3*OW +: OW], {70'hABCDE, 5'h03});
    checkOutput("eg_ready_low", ifa.array_ready_o[3], 0);
    applyStimulus(2);
    checkOutput("eg_v_hold", ifa.out_v_o[3], 1);
    checkOutput("eg_data_hold", ifa.out_data_o[3*OW +: OW], {70'hABCDE, 5'h03});
    checkOutput("eg_ready_hold", ifa.array_ready_o[3], 0);
    checkOutput("eg_busy", idlea, 0);
    ifa.out_ready_i[3] = 1'b1;
    applyStimulus(0);
    checkOutput("eg_ready_pass", ifa.array_ready_o[3], 1);
    applyStimulus(1);
    checkOutput("eg_drained", ifa.out_v_o[3], 0);
    for (int i = 0; i < 10; i++) begin
      ifa.array_data_i[3*PW +: PW] = {70'(i + 100), 5'h1F, 5'(i)};
      ifa.array_v_i[3] = 1'b1;
      applyStimulus(1);
      checkOutput("eg_b2b_v", ifa.out_v_o[3], 1);
      checkOutput("eg_b2b_data", ifa.out_data_o[3*OW +: OW], {70'(i + 100), 5'(i)});
    end
    ifa.array_v_i[3] = 1'b0;
    applyStimulus(1);
    checkOutput("eg_b2b_end", ifa.out_v_o[3], 0);

    $display("[TB] reset mid-operation");
    ifb.array_ready_i = 4'hF;
    ifb.in_v_i[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ifb.in_data_i[0 +: OW] = orig(70'(i + 21), 5'(i));
      applyStimulus(1);
    end
    ifb.in_v_i[0] = 1'b0;
    ifb.array_ready_i = 4'h0;
    applyStimulus(1);
    checkOutput("b_cred3", credb[4:0], 3);
    checkOutput("b_buffered", ifb.array_v_o[0], 1);
    checkOutput("b_busy", idleb, 0);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("arst_v", ifb.array_v_o, 0);
    checkOutput("arst_cred", credb, 0);
    checkOutput("arst_idle", idleb, 1);
    checkOutput("arst_in_ready", ifb.in_ready_o, 0);
    checkOutput("arst_ret_ready", ifb.ret_ready_o, 0);
    checkOutput("arst_err_a", erra, 0);
    applyStimulus(1);
    reset_n = 1'b1;
    applyStimulus(1);
    checkOutput("rel_v", ifb.array_v_o, 0);
    checkOutput("rel_idle", idleb, 1);
    checkOutput("rel_in_ready", ifb.in_ready_o, 4'hF);
    ifb.array_ready_i = 4'hF;
    ifb.in_data_i[2*OW +: OW] = orig(70'h55, 5'h07);
    ifb.in_v_i[2] = 1'b1;
    applyStimulus(1);
    ifb.in_v_i[2] = 1'b0;
    applyStimulus(0);
    checkOutput("mode1_v", ifb.array_v_o[2], 1);
    checkOutput("mode1_data", ifb.array_data_o[2*PW +: PW], {70'h55, 5'h15, 5'h07});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
